// File: rtl/midi_uart_rx_fifo.sv
// midi_uart_rx_fifo: MIDI serial receiver with start/stop validation and a show-ahead byte FIFO.
module midi_uart_rx_fifo #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD = 31250,
    parameter int DATA_BITS = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 MIDI_RX,
    output logic                 byte_valid,
    output logic [DATA_BITS-1:0] byte_data,
    input  logic                 byte_ready,
    output logic [CW-1:0]        fifo_count,
    output logic                 framing_error,
    output logic                 overflow
);
    localparam int TICKS = CLK_HZ / BAUD;
    localparam int HALF = TICKS / 2;
    localparam int TW = $clog2(TICKS);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] HALF_END = TW'(HALF - 1);
    localparam logic [TW-1:0] TICK_END = TW'(TICKS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} rxState_t;

    rxState_t state, nextState;
    logic rxMeta, rxS;
    logic [TW-1:0] cnt;
    logic [BW-1:0] bitIdx;
    logic [DATA_BITS-1:0] shiftReg;
    logic halfHit, bitHit, cntRun, cntClr, enterData, sampleBit, stopGood, stopBad;
    logic pushReq, pop, full, doWrite;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count;

    always_ff @(posedge CLOCK_50) begin
        if (reset) {rxMeta, rxS} <= 2'b11;
        else {rxMeta, rxS} <= {MIDI_RX, rxMeta};
    end

    assign halfHit = cnt == HALF_END;
    assign bitHit = cnt == TICK_END;

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: nextState = rxS ? IDLE : START;
            START: nextState = !halfHit ? START : rxS ? IDLE : DATA;
            DATA: nextState = (bitHit && bitIdx == LAST_BIT) ? STOP : DATA;
            STOP: nextState = !bitHit ? STOP : rxS ? IDLE : BRK;
            BRK: nextState = rxS ? IDLE : BRK;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        cntRun = state == START || state == DATA || state == STOP;
        cntClr = (state == START) ? halfHit : bitHit;
        enterData = state == START && halfHit && !rxS;
        sampleBit = state == DATA && bitHit;
        stopGood = state == STOP && bitHit && rxS;
        stopBad = state == STOP && bitHit && !rxS;
    end

    // Data arrives LSB first, so shifting in from the top leaves bit 0 at position 0.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt <= '0;
            bitIdx <= '0;
            shiftReg <= '0;
            pushReq <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            cnt <= (!cntRun || cntClr) ? '0 : cnt + 1'b1;
            bitIdx <= enterData ? '0 : sampleBit ? bitIdx + 1'b1 : bitIdx;
            shiftReg <= sampleBit ? {rxS, shiftReg[DATA_BITS-1:1]} : shiftReg;
            pushReq <= stopGood;
            framing_error <= stopBad;
        end
    end

    always_comb begin
        byte_valid = count != '0;
        byte_data = byte_valid ? mem[rdPtr] : '0;
        fifo_count = count;
        pop = byte_valid && byte_ready;
        full = count == FULL;
        doWrite = pushReq && (!full || pop);
    end

    always_ff @(posedge CLOCK_50) begin
        if (doWrite) mem[wrPtr] <= shiftReg;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else begin
            wrPtr <= doWrite ? wrPtr + 1'b1 : wrPtr;
            rdPtr <= pop ? rdPtr + 1'b1 : rdPtr;
            count <= count + CW'(doWrite) - CW'(pop);
            overflow <= pushReq && full && !pop;
        end
    end
endmodule

// File: tb/tb_midi_uart_rx_fifo.sv
// tb_midi_uart_rx_fifo: randomized and directed frames checked cycle-by-cycle against a queue model.
module tb_midi_uart_rx_fifo;
    localparam int CLK_HZ = 625000;
    localparam int BAUD = 31250;
    localparam int DB = 8;
    localparam int DEPTH = 4;
    localparam int T = CLK_HZ / BAUD;
    localparam int H = T / 2;
    // Cycles from driving the start edge to the pushed byte becoming visible (2 sync flops + t0+HALF+9T+2).
    localparam int LAT = H + (DB + 1) * T + 4;

    logic CLOCK_50 = 1'b0;
    logic reset = 1'b1;
    logic MIDI_RX = 1'b1;
    logic byte_ready = 1'b0;
    logic byte_valid, framing_error, overflow;
    logic [DB-1:0] byte_data;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    midi_uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .MIDI_RX(MIDI_RX),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .fifo_count(fifo_count),
        .framing_error(framing_error),
        .overflow(overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int at;
        logic [DB-1:0] d;
        bit fe;
    } ev_t;

    ev_t ev[$];
    logic [DB-1:0] q[$];
    logic [DB-1:0] got[$];
    int cyc = 0, errors = 0, checks = 0;
    int feCount = 0, ovCount = 0, validCycles = 0, firstValid = -1, maxCount = 0;
    bit expFe = 0, expOv = 0, checking = 0, rnd = 0;

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, a, e);
        end
    endtask

    task automatic checkGot(input string n, input int len, input logic [31:0] e);
        check({n, "_len"}, got.size(), len);
        for (int i = 0; i < len; i++)
            check(n, (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(e[8*i +: 8]));
    endtask

    // Model: a queue FIFO fed by frame events whose timing follows from the sample-point formula.
    initial forever begin
        @(posedge CLOCK_50);
        cyc++;
        expFe = 0;
        expOv = 0;
        if (reset) begin
            q.delete();
            ev.delete();
        end else begin
            if (q.size() != 0 && byte_ready) void'(q.pop_front());
            while (ev.size() != 0 && ev[0].at <= cyc) begin
                if (ev[0].fe) expFe = 1;
                else if (q.size() < DEPTH) q.push_back(ev[0].d);
                else expOv = 1;
                void'(ev.pop_front());
            end
        end
    end

    initial forever begin
        @(negedge CLOCK_50);
        if (checking) begin
            check("byte_valid", byte_valid, q.size() != 0);
            check("byte_data", byte_data, q.size() != 0 ? q[0] : '0);
            check("fifo_count", fifo_count, q.size());
            check("framing_error", framing_error, expFe);
            check("overflow", overflow, expOv);
            if (byte_valid && byte_ready) got.push_back(byte_data);
            if (byte_valid) validCycles++;
            if (byte_valid && firstValid < 0) firstValid = cyc;
            if (int'(fifo_count) > maxCount) maxCount = fifo_count;
            feCount += int'(framing_error);
            ovCount += int'(overflow);
        end
    end

    initial forever begin
        @(posedge CLOCK_50);
        #1;
        if (rnd) byte_ready = 1'($urandom_range(0, 1));
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic sendFrame(input logic [DB-1:0] d, input bit stopBit, input bit pulse);
        logic [DB+1:0] bits;
        ev_t e;
        int k;
        bits = {stopBit, d, 1'b0};
        k = cyc;
        e.d = d;
        e.fe = !stopBit;
        e.at = stopBit ? k + LAT : k + LAT - 1;
        ev.push_back(e);
        for (int c = 0; c < (DB + 2) * T; c++) begin
            MIDI_RX = bits[c / T];
            if (pulse) byte_ready = (cyc == k + LAT - 1);
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    initial begin
        int k, fe0, ov0;
        @(posedge CLOCK_50);
        #1;
        checking = 1;
        idle(1);
        reset = 0;
        check("reset_count", fifo_count, 0);
        check("reset_valid", byte_valid, 0);
        idle(3);

        byte_ready = 1;
        got.delete();
        validCycles = 0;
        firstValid = -1;
        maxCount = 0;
        k = cyc;
        sendFrame(8'h90, 1, 0);
        idle(T);
        check("t1_latency", firstValid - k, H + 9 * T + 4);
        check("t1_valid_cycles", validCycles, 1);
        check("t1_peak", maxCount, 1);
        check("t1_flags", feCount + ovCount, 0);
        checkGot("t1_data", 1, 32'h90);

        byte_ready = 0;
        got.delete();
        sendFrame(8'h90, 1, 0);
        sendFrame(8'h3C, 1, 0);
        sendFrame(8'h7F, 1, 0);
        idle(T);
        check("t2_count", fifo_count, 3);
        byte_ready = 1;
        idle(3);
        check("t2_drained_valid", byte_valid, 0);
        checkGot("t2_data", 3, 32'h007F3C90);

        got.delete();
        fe0 = feCount;
        MIDI_RX = 0;
        idle(H / 2);
        MIDI_RX = 1;
        idle(2 * T);
        check("t3_glitch_flags", feCount - fe0, 0);
        check("t3_glitch_nopush", got.size(), 0);
        sendFrame(8'h45, 1, 0);
        idle(T);
        checkGot("t3_data", 1, 32'h45);

        got.delete();
        fe0 = feCount;
        sendFrame(8'hAA, 0, 0);
        idle(15 * T);
        MIDI_RX = 1;
        idle(T);
        sendFrame(8'h12, 1, 0);
        idle(T);
        check("t4_fe_pulses", feCount - fe0, 1);
        checkGot("t4_data", 1, 32'h12);

        byte_ready = 0;
        ov0 = ovCount;
        for (int i = 1; i <= 5; i++) sendFrame(DB'(i), 1, 0);
        idle(T);
        check("t5_count_full", fifo_count, 4);
        check("t5_overflow", ovCount - ov0, 1);
        got.delete();
        byte_ready = 1;
        idle(6);
        checkGot("t5_drain", 4, 32'h04030201);
        byte_ready = 0;
        ov0 = ovCount;
        for (int i = 1; i <= 4; i++) sendFrame(DB'(i), 1, 0);
        sendFrame(8'h05, 1, 1);
        got.delete();
        idle(T);
        check("t5_pop_push_ov", ovCount - ov0, 0);
        check("t5_pop_push_count", fifo_count, 4);
        byte_ready = 1;
        idle(6);
        checkGot("t5_drain2", 4, 32'h05040302);

        byte_ready = 0;
        sendFrame(8'h77, 1, 0);
        idle(2);
        check("t6_preload", fifo_count, 1);
        MIDI_RX = 0;
        idle(T);
        MIDI_RX = 1;
        idle(T);
        MIDI_RX = 0;
        idle(T);
        MIDI_RX = 1;
        idle(T / 2);
        reset = 1;
        idle(1);
        reset = 0;
        idle(T * 12);
        check("t6_count", fifo_count, 0);
        check("t6_valid", byte_valid, 0);
        got.delete();
        byte_ready = 1;
        sendFrame(8'h66, 1, 0);
        idle(T);
        checkGot("t6_data", 1, 32'h66);

        rnd = 1;
        for (int i = 0; i < 30; i++) begin
            bit good;
            good = $urandom_range(0, 7) != 0;
            sendFrame(DB'($urandom), good, 0);
            if (!good) begin
                idle($urandom_range(0, 3 * T));
                MIDI_RX = 1;
                idle(3);
            end else idle($urandom_range(0, T));
        end
        idle(T);
        rnd = 0;
        byte_ready = 1;
        idle(DEPTH + 2);
        check("final_empty", fifo_count, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
